// File: rtl/shiftbuffer_drain.sv
`default_nettype none
// ============================================================================
// Module   : shiftbuffer_drain
// Desc     : Consumer end of the shiftbuffer stall interface. Buffers words in
//            a first-word-fall-through FIFO and drives the upstream stall
//            from occupancy with hysteresis. Optional statistics outputs are
//            enabled by defining SHIFTBUFFER_DRAIN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shiftbuffer_drain #(
    parameter int p_width  = 32,
    parameter int p_depth  = 4,
    parameter int p_resume = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [p_width-1:0]         in,
    input  logic                       in_valid,
    output logic                       o_stall,
    output logic [p_width-1:0]         out,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef SHIFTBUFFER_DRAIN_STATS_EN
    output logic [31:0]                o_stall_cycles,
    output logic [$clog2(p_depth):0]   o_max_level,
`endif
    output logic [$clog2(p_depth):0]   o_level
);

    localparam int PW = $clog2(p_depth);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] c_full   = LW'(p_depth);
    localparam logic [LW-1:0] c_resume = LW'(p_resume);

    if ((p_depth < 2) || ((p_depth & (p_depth - 1)) != 0) || (p_resume >= p_depth)) begin : g_bad_params
        $fatal(1, "shiftbuffer_drain: illegal p_depth/p_resume combination");
    end

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [p_width-1:0] r_mem [p_depth];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_count;
    logic [LW-1:0]      w_count_next;
    logic               w_acc;
    logic               w_pop;

    // Acceptance looks at the registered state so a word held during a stall
    // is captured exactly once, on the first cycle after the stall releases.
    assign w_acc        = in_valid && (r_state == ST_RUN);
    assign out_valid    = (r_count != '0);
    assign w_pop        = out_valid && out_ready;
    assign w_count_next = r_count + LW'(w_acc) - LW'(w_pop);

    assign out     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_count;
    assign o_stall = (r_state == ST_STALL);

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_count_next == c_full) begin
                    w_state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (w_count_next <= c_resume) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

`ifdef SHIFTBUFFER_DRAIN_STATS_EN
    logic [31:0]   r_stall_cycles;
    logic [LW-1:0] r_max_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
            r_max_level    <= '0;
        end else begin
            if ((r_state == ST_STALL) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_count_next > r_max_level) begin
                r_max_level <= w_count_next;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_max_level    = r_max_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shiftbuffer_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftbuffer_drain
// Desc     : Randomised and directed bench for shiftbuffer_drain against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftbuffer_drain;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int RESUME = 1;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic             i_clk;
    logic             i_rst_n;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             o_stall;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    o_level;
`ifdef SHIFTBUFFER_DRAIN_STATS_EN
    logic [31:0]      o_stall_cycles;
    logic [LW-1:0]    o_max_level;
`endif

    shiftbuffer_drain #(
        .p_width  (WIDTH),
        .p_depth  (DEPTH),
        .p_resume (RESUME)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .in             (in),
        .in_valid       (in_valid),
        .o_stall        (o_stall),
        .out            (out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef SHIFTBUFFER_DRAIN_STATS_EN
        .o_stall_cycles (o_stall_cycles),
        .o_max_level    (o_max_level),
`endif
        .o_level        (o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the FIFO is a plain queue, stall is a hysteresis flag.
    logic [WIDTH-1:0] q[$];
    logic             m_stall = 1'b0;
    logic             m_acc   = 1'b0;
    logic [WIDTH-1:0] popped[$];

    function automatic logic [WIDTH-1:0] m_out();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    task automatic tick();
        logic             a;
        logic             p;
        logic [WIDTH-1:0] d;
        a = in_valid && !m_stall;
        p = (q.size() != 0) && out_ready;
        d = in;
        @(posedge i_clk);
        #1;
        if (p) popped.push_back(q.pop_front());
        if (a) q.push_back(d);
        if (!m_stall && q.size() == DEPTH)      m_stall = 1'b1;
        else if (m_stall && q.size() <= RESUME) m_stall = 1'b0;
        m_acc = a;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #7;
        q.delete();
        popped.delete();
        m_stall = 1'b0;
        m_acc   = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = 1'b1;
        i_rst_n = 1'b0;
        #3;
        n_cmp++; if (o_stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out !== '0)         begin n_err++; $display("FAIL reset_out: got %h want 0", out); end
        n_cmp++; if (o_level !== '0)     begin n_err++; $display("FAIL reset_level: got %0d want 0", o_level); end
        in_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in = words[i]; in_valid = 1'b1;
            tick();
            n_cmp++; if (out !== words[i]) begin n_err++; $display("FAIL stream_out[%0d]: got %h want %h", i, out, words[i]); end
            n_cmp++; if (o_level !== LW'(1) || o_stall !== 1'b0) begin
                n_err++; $display("FAIL stream_level[%0d]: got lvl=%0d stall=%b want lvl=1 stall=0", i, o_level, o_stall);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out !== '0) begin n_err++; $display("FAIL stream_empty: got v=%b out=%h want v=0 out=0", out_valid, out); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in = 32'hA0 + i; in_valid = 1'b1;
            tick();
            n_cmp++; if (o_level !== LW'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, o_level, i + 1); end
        end
        n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall: got %b want 1", o_stall); end
        in = 32'hA4;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (o_level !== LW'(4) || out !== 32'hA0) begin
                n_err++; $display("FAIL hold[%0d]: got lvl=%0d out=%h want lvl=4 out=a0", i, o_level, out);
            end
        end
    endtask

    task automatic test_drain();
        logic             exp_stall [5];
        logic [WIDTH-1:0] seen[$];
        exp_stall = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen.push_back(out);
            if (i == 4) in_valid = 1'b0;
            tick();
            n_cmp++; if (o_stall !== exp_stall[i]) begin n_err++; $display("FAIL drain_stall[%0d]: got %b want %b", i, o_stall, exp_stall[i]); end
        end
        n_cmp++; if (seen.size() != 5) begin n_err++; $display("FAIL drain_count: got %0d want 5", seen.size()); end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            n_cmp++; if (seen[i] !== 32'hA0 + i) begin n_err++; $display("FAIL drain_order[%0d]: got %h want %h", i, seen[i], 32'hA0 + i); end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in = $urandom; in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = $urandom; in_valid = 1'b1;
            tick();
            n_cmp++; if (o_level !== LW'(2) || out !== m_out() || o_stall !== 1'b0) begin
                n_err++; $display("FAIL b2b[%0d]: got lvl=%0d out=%h stall=%b want lvl=2 out=%h stall=0", i, o_level, out, o_stall, m_out());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in = $urandom; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (o_level !== LW'(3) || o_stall !== 1'b1) begin n_err++; $display("FAIL pre_areset: got lvl=%0d stall=%b want lvl=3 stall=1", o_level, o_stall); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_stall !== 1'b0 || out_valid !== 1'b0 || o_level !== '0) begin
            n_err++; $display("FAIL areset: got stall=%b v=%b lvl=%0d want 0 0 0", o_stall, out_valid, o_level);
        end
        do_reset();
        in = 32'h55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out !== 32'h55 || o_level !== LW'(1)) begin
            n_err++; $display("FAIL post_areset: got v=%b out=%h lvl=%0d want 1 55 1", out_valid, out, o_level);
        end
    endtask

    task automatic test_random();
        do_reset();
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in       = $urandom;
            end
            out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++; if (out !== m_out() || out_valid !== (q.size() != 0) || o_level !== LW'(q.size()) || o_stall !== m_stall) begin
                n_err++;
                $display("FAIL random[%0d]: got out=%h v=%b lvl=%0d stall=%b want out=%h v=%b lvl=%0d stall=%b",
                         i, out, out_valid, o_level, o_stall, m_out(), q.size() != 0, q.size(), m_stall);
            end
        end
        in_valid = 1'b0;
    endtask

`ifdef SHIFTBUFFER_DRAIN_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in = 32'hA0 + i; in_valid = 1'b1;
            tick();
        end
        in = 32'hA4;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        n_cmp++; if (o_stall_cycles !== 32'd10) begin n_err++; $display("FAIL stall_cycles: got %0d want 10", o_stall_cycles); end
        n_cmp++; if (o_max_level !== LW'(4)) begin n_err++; $display("FAIL max_level: got %0d want 4", o_max_level); end
    endtask
`endif

    initial begin
        i_rst_n   = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_fill_stall();
        test_drain();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef SHIFTBUFFER_DRAIN_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shiftbuffer_drain.md
Name: shiftbuffer_drain

Overview:
- Consumer-side end of the shiftbuffer stall interface.
- Takes the shiftbuffer's out/out_valid, holds the words in a small first-word-fall-through FIFO, and presents them downstream with valid/ready.
- Drives the shiftbuffer's stall input from FIFO occupancy, with hysteresis, so that no word is lost or duplicated when downstream back-pressures.

Parameters:
p_width, 32, data word width in bits
p_depth, 4, FIFO entries; power of two, at least 2
p_resume, 1, occupancy at or below which stall releases; must be less than p_depth

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
in  input  p_width  data from shiftbuffer out
in_valid  input  1  shiftbuffer out_valid
o_stall  output  1  to shiftbuffer i_stall; registered
out  output  p_width  head-of-FIFO data
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts head this cycle
o_level  output  $clog2(p_depth)+1  current occupancy, 0..p_depth

Behaviour:
- Reset (async assert on i_rst_n low, sync release):
  - count=0, wr_ptr=0, rd_ptr=0, state=RUN.
  - o_stall=0, out_valid=0, out=0, o_level=0.
  - Storage contents are not reset.
- Accept: acc = in_valid && (state==RUN). This uses the registered state, not the next state.
  - While stalled, the shiftbuffer holds its last stage, so in/in_valid stay asserted with the same word. That word must not be captured until stall drops; it is then captured exactly once.
- Pop: pop = out_valid && out_ready.
- Write: on acc, mem[wr_ptr] <= in and wr_ptr advances. On pop, rd_ptr advances. Both pointers wrap modulo p_depth.
- count_next = count + acc - pop. Simultaneous acc and pop leaves count unchanged; both pointers advance.
- out_valid = (count != 0).
- out = mem[rd_ptr] when out_valid, else forced to 0.
- o_level = count.
- Latency: a word accepted at edge N appears on out/out_valid after edge N (first-word fall-through). No combinational path from in to out.
- FSM, two states; o_stall = (state==STALL):
  - RUN -> STALL when count_next == p_depth.
  - STALL -> RUN when count_next <= p_resume.
  - Otherwise the state holds.
- Boundaries:
  - Full: count==p_depth implies state==STALL, so acc=0 and overflow is impossible by construction.
  - Empty: pop is impossible because out_valid=0; out_ready is ignored.
  - Draining: in STALL, pops continue; in_valid is ignored.
  - Reset mid-transfer: all held words are discarded and o_stall drops immediately (async).
  - Illegal parameters: p_depth not a power of two, p_depth < 2, or p_resume >= p_depth is a simulation-time fatal error.

Optional Feature:
Macro SHIFTBUFFER_DRAIN_STATS_EN
- Defined:
  - Adds output o_stall_cycles, 32 bits, reset 0.
  - Increments every cycle o_stall==1 and saturates at 32'hFFFFFFFF.
  - Adds output o_max_level, same width as o_level, reset 0, holding the highest count seen since reset.
- Not defined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then in_valid=1 with in=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out shows 0x11,0x22,0x33 one cycle after each accept; o_stall stays 0; o_level never exceeds 1.
2. out_ready=0, feed 0xA0..0xA3 -> o_level reaches 4 and o_stall=1 on the cycle after 0xA3 is accepted. Then hold in=0xA4 with in_valid=1 for 5 cycles -> no accept and o_level stays 4.
3. From scenario 2, raise out_ready -> pops 0xA0,0xA1,0xA2. o_stall falls in the cycle after level reaches 1. 0xA4 is accepted exactly once and output order is 0xA0..0xA4 with no duplicate.
4. Level 2, RUN, in_valid=1 and out_ready=1 held for 8 cycles -> o_level constant 2; pointers wrap twice; data order preserved.
5. Assert i_rst_n=0 mid-cycle while level=3 and o_stall=1 -> o_stall, out_valid and o_level go to 0 without waiting for a clock edge. After release, the first accepted word 0x55 appears on out one cycle later.
6. With SHIFTBUFFER_DRAIN_STATS_EN defined, run scenario 2 holding the stall for 10 cycles -> o_stall_cycles=10 and o_max_level=4.
